// File: rtl/dds_sine_gen_if.sv
// Control and sample bus for the DDS sine generator.
// The master drives the tuning controls; the slave (the generator) returns
// the sample tick, the output valid strobe and the signed sample.
interface dds_sine_gen_if #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 16,
    parameter int AMP_W   = 16,
    parameter int DIV_W   = 16
);
    logic                      en;
    logic                      sync;
    logic [PHASE_W-1:0]        ftw;
    logic [PHASE_W-1:0]        phase_ofs;
    logic [AMP_W-1:0]          amp;
    logic [DIV_W-1:0]          div;
    logic                      sample_tick;
    logic                      out_valid;
    logic signed [OUT_W-1:0]   sample_out;

    modport master (
        output en, sync, ftw, phase_ofs, amp, div,
        input  sample_tick, out_valid, sample_out
    );

    modport slave (
        input  en, sync, ftw, phase_ofs, amp, div,
        output sample_tick, out_valid, sample_out
    );
endinterface

// File: rtl/dds_sine_gen.sv
// Direct-digital-synthesis sine generator.
// A programmable divider produces sample ticks; each tick takes the current
// phase into a three-stage pipeline (quadrant fold, quarter-wave ROM read,
// sign restore and amplitude scaling) and advances the phase accumulator.
module dds_sine_gen #(
    parameter int PHASE_W = 32,
    parameter int LUT_AW  = 8,
    parameter int OUT_W   = 16,
    parameter int AMP_W   = 16,
    parameter int DIV_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    dds_sine_gen_if.slave   bus
);
    localparam int  QN     = 2**LUT_AW;
    localparam int  Q_W    = OUT_W - 1;
    localparam int  PROD_W = OUT_W + AMP_W + 1;
    localparam real PI     = 3.14159265358979323846;
    localparam real Q_MAX  = real'(2**(OUT_W-1) - 1);
    localparam logic signed [PROD_W-1:0] RND = PROD_W'(2**(AMP_W-1));

    // Quarter-wave table, sampled at half-step offsets so the folded
    // quadrants mirror exactly without duplicating the 0 and peak points.
    logic [Q_W-1:0] w_rom [QN];

    genvar gi;
    generate
        for (gi = 0; gi < QN; gi++) begin : g_rom
            localparam real ANG = PI / 2.0 * (real'(gi) + 0.5) / real'(QN);
            localparam int  VAL = $rtoi(Q_MAX * $sin(ANG) + 0.5);
            assign w_rom[gi] = Q_W'(VAL);
        end
    endgenerate

    logic [DIV_W-1:0]          r_div_cnt;
    logic [PHASE_W-1:0]        r_phase_acc;
    logic [LUT_AW-1:0]         r_idx;
    logic                      r_neg1;
    logic                      r_v1;
    logic [Q_W-1:0]            r_rom_q;
    logic                      r_neg2;
    logic                      r_v2;
    logic                      r_out_valid;
    logic signed [OUT_W-1:0]   r_sample_out;

    logic                      w_tick;
    logic [1:0]                w_quad;
    logic [LUT_AW-1:0]         w_idx_raw;
    logic [LUT_AW-1:0]         w_idx;
    logic signed [OUT_W-1:0]   w_q_ext;
    logic signed [OUT_W-1:0]   w_s;
    logic signed [AMP_W:0]     w_amp_s;
    logic signed [PROD_W-1:0]  w_prod;
    logic signed [PROD_W-1:0]  w_sum;

    // Divider compares against the live div value; no tick is shown while reset is held.
    assign w_tick    = bus.en && !reset && (r_div_cnt == bus.div);

    // Fold the phase into one quadrant: odd quadrants run the table backwards,
    // the upper half-cycle negates.
    assign w_quad    = r_phase_acc[PHASE_W-1 -: 2];
    assign w_idx_raw = r_phase_acc[PHASE_W-3 -: LUT_AW];
    assign w_idx     = w_quad[0] ? ~w_idx_raw : w_idx_raw;

    // Signed restore and rounded amplitude scale; the product width holds the
    // full range so the arithmetic shift result always fits OUT_W.
    assign w_q_ext   = {1'b0, r_rom_q};
    assign w_s       = r_neg2 ? -w_q_ext : w_q_ext;
    assign w_amp_s   = {1'b0, bus.amp};
    assign w_prod    = PROD_W'(w_s) * PROD_W'(w_amp_s);
    assign w_sum     = w_prod + RND;

    // Sample-rate divider: counts while enabled, restarts on each tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (bus.en) begin
            if (w_tick) r_div_cnt <= '0;
            else        r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Phase accumulator: sync reloads the offset and wins over the tick advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase_acc <= '0;
        end else if (bus.sync) begin
            r_phase_acc <= bus.phase_ofs;
        end else if (w_tick) begin
            r_phase_acc <= r_phase_acc + bus.ftw;
        end
    end

    // Stage 1: capture folded table index and sign of the ticked phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1   <= 1'b0;
            r_idx  <= '0;
            r_neg1 <= 1'b0;
        end else begin
            r_v1 <= w_tick;
            if (w_tick) begin
                r_idx  <= w_idx;
                r_neg1 <= w_quad[1];
            end
        end
    end

    // Stage 2: synchronous quarter-wave table read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2    <= 1'b0;
            r_rom_q <= '0;
            r_neg2  <= 1'b0;
        end else begin
            r_v2    <= r_v1;
            r_rom_q <= w_rom[r_idx];
            r_neg2  <= r_neg1;
        end
    end

    // Stage 3: scaled sample register, held between valid strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_sample_out <= '0;
        end else begin
            r_out_valid <= r_v2;
            if (r_v2) r_sample_out <= OUT_W'(w_sum >>> AMP_W);
        end
    end

    assign bus.sample_tick = w_tick;
    assign bus.out_valid   = r_out_valid;
    assign bus.sample_out  = r_sample_out;
endmodule

// File: tb/tb_dds_sine_gen.sv
// Directed bench for the DDS sine generator: quarter-cycle tuning word so
// every sample lands on a known table entry, with hand-computed values.
module tb_dds_sine_gen;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dds_sine_gen_if bus_if ();

    dds_sine_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Full-scale and half-scale quarter-phase sequences
    logic signed [15:0] seq_full [4] = '{16'sd101, 16'sd32767, -16'sd101, -16'sd32767};
    logic signed [15:0] seq_half [4] = '{16'sd51, 16'sd16384, -16'sd50, -16'sd16383};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        bus_if.en        = 1'b0;
        bus_if.sync      = 1'b0;
        bus_if.ftw       = 32'h4000_0000;
        bus_if.phase_ofs = 32'h0;
        bus_if.amp       = 16'hFFFF;
        bus_if.div       = 16'd0;
        repeat (3) cyc();
        checks++;
        if (bus_if.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %b exp 0", bus_if.out_valid);
        end
        checks++;
        if (bus_if.sample_out !== 16'sd0) begin
            errors++; $display("FAIL reset_sample got %0d exp 0", bus_if.sample_out);
        end
        checks++;
        if (bus_if.sample_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick got %b exp 0", bus_if.sample_tick);
        end
        bus_if.en = 1'b1;
        reset     = 1'b0;
        #1;
        checks++;
        if (bus_if.sample_tick !== 1'b1) begin
            errors++; $display("FAIL first_tick got %b exp 1", bus_if.sample_tick);
        end
        $display("tx reset released, first tick observed=%b", bus_if.sample_tick);
    endtask

    task automatic test_basic();
        for (int k = 1; k <= 10; k++) begin
            cyc();
            checks++;
            if (bus_if.out_valid !== (k >= 3)) begin
                errors++; $display("FAIL basic_valid k=%0d got %b exp %b", k, bus_if.out_valid, (k >= 3));
            end
            if (k >= 3) begin
                checks++;
                if (bus_if.sample_out !== seq_full[(k-3)%4]) begin
                    errors++; $display("FAIL basic_sample k=%0d got %0d exp %0d", k, bus_if.sample_out, seq_full[(k-3)%4]);
                end
                $display("tx basic k=%0d sample=%0d", k, bus_if.sample_out);
            end
        end
    endtask

    task automatic test_div();
        logic [19:0] tick_vec;
        logic [19:0] valid_vec;
        tick_vec   = '0;
        valid_vec  = '0;
        bus_if.div = 16'd3;
        for (int i = 0; i < 20; i++) begin
            if (i == 16) bus_if.div = 16'd0;
            #1;
            tick_vec[i]  = bus_if.sample_tick;
            valid_vec[i] = bus_if.out_valid;
            cyc();
        end
        checks++;
        if (tick_vec !== 20'b1111_1000_1000_1000_1000) begin
            errors++; $display("FAIL div_ticks got %b exp %b", tick_vec, 20'b1111_1000_1000_1000_1000);
        end
        checks++;
        if (valid_vec !== 20'b1100_0100_0100_0100_0111) begin
            errors++; $display("FAIL div_valids got %b exp %b", valid_vec, 20'b1100_0100_0100_0100_0111);
        end
        $display("tx div ticks=%b valids=%b", tick_vec, valid_vec);
    endtask

    task automatic test_amp();
        bus_if.sync      = 1'b1;
        bus_if.phase_ofs = 32'h0;
        cyc();
        bus_if.sync = 1'b0;
        bus_if.amp  = 16'h8000;
        repeat (3) cyc();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sample_out !== seq_half[k]) begin
                errors++; $display("FAIL amp_half k=%0d got v=%b %0d exp v=1 %0d", k, bus_if.out_valid, bus_if.sample_out, seq_half[k]);
            end
            $display("tx amp_half k=%0d sample=%0d", k, bus_if.sample_out);
            cyc();
        end
        bus_if.amp = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            cyc();
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sample_out !== 16'sd0) begin
                errors++; $display("FAIL amp_zero k=%0d got v=%b %0d exp v=1 0", k, bus_if.out_valid, bus_if.sample_out);
            end
        end
    endtask

    task automatic test_sync();
        logic signed [15:0] exp_s [3];
        exp_s = '{16'sd101, -16'sd101, -16'sd32767};
        bus_if.amp       = 16'hFFFF;
        bus_if.sync      = 1'b1;
        bus_if.phase_ofs = 32'h0;
        cyc();
        bus_if.phase_ofs = 32'h8000_0000;
        cyc();
        bus_if.sync = 1'b0;
        cyc();
        cyc();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sample_out !== exp_s[k]) begin
                errors++; $display("FAIL sync k=%0d got v=%b %0d exp v=1 %0d", k, bus_if.out_valid, bus_if.sample_out, exp_s[k]);
            end
            $display("tx sync k=%0d sample=%0d", k, bus_if.sample_out);
            if (k < 2) cyc();
        end
    endtask

    task automatic test_enable();
        logic signed [15:0] exp_r [3];
        exp_r = '{-16'sd101, -16'sd32767, 16'sd101};
        bus_if.sync      = 1'b1;
        bus_if.phase_ofs = 32'h0;
        cyc();
        bus_if.sync = 1'b0;
        cyc();
        cyc();
        bus_if.en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            #1;
            checks++;
            if (bus_if.sample_tick !== 1'b0) begin
                errors++; $display("FAIL en_tick j=%0d got %b exp 0", j, bus_if.sample_tick);
            end
            checks++;
            if (bus_if.out_valid !== (j <= 2)) begin
                errors++; $display("FAIL en_drain j=%0d got %b exp %b", j, bus_if.out_valid, (j <= 2));
            end
            if (j == 1 || j == 2) begin
                checks++;
                if (bus_if.sample_out !== seq_full[j-1]) begin
                    errors++; $display("FAIL en_drain_val j=%0d got %0d exp %0d", j, bus_if.sample_out, seq_full[j-1]);
                end
            end
            cyc();
        end
        bus_if.en = 1'b1;
        #1;
        checks++;
        if (bus_if.sample_tick !== 1'b1) begin
            errors++; $display("FAIL en_resume_tick got %b exp 1", bus_if.sample_tick);
        end
        repeat (3) cyc();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sample_out !== exp_r[k]) begin
                errors++; $display("FAIL en_resume k=%0d got v=%b %0d exp v=1 %0d", k, bus_if.out_valid, bus_if.sample_out, exp_r[k]);
            end
            $display("tx resume k=%0d sample=%0d", k, bus_if.sample_out);
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        logic signed [15:0] exp_w [3];
        exp_w = '{16'sd101, -16'sd101, -16'sd101};
        cyc();
        reset = 1'b1;
        #1;
        checks++;
        if (bus_if.out_valid !== 1'b0 || bus_if.sample_out !== 16'sd0) begin
            errors++; $display("FAIL mid_reset got v=%b %0d exp v=0 0", bus_if.out_valid, bus_if.sample_out);
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++;
            if (bus_if.out_valid !== 1'b0) begin
                errors++; $display("FAIL mid_reset_hold k=%0d got %b exp 0", k, bus_if.out_valid);
            end
        end
        bus_if.ftw = 32'hFFFF_FFFF;
        bus_if.amp = 16'hFFFF;
        reset      = 1'b0;
        repeat (3) cyc();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (bus_if.out_valid !== 1'b1 || bus_if.sample_out !== exp_w[k]) begin
                errors++; $display("FAIL wrap k=%0d got v=%b %0d exp v=1 %0d", k, bus_if.out_valid, bus_if.sample_out, exp_w[k]);
            end
            checks++;
            if ($isunknown(bus_if.sample_out)) begin
                errors++; $display("FAIL wrap_x k=%0d got %b exp known", k, bus_if.sample_out);
            end
            $display("tx wrap k=%0d sample=%0d", k, bus_if.sample_out);
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div();
        test_amp();
        test_sync();
        test_enable();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
